// File: rtl/aesl_axis_block_detector.sv
// AXI-Stream blocked-channel detector for the cosim deadlock monitor.
// Each channel counts consecutive one-sided wait cycles and raises its
// axis_block_sigs bit once THRESHOLD of them have gone by. The first channel
// to block is latched (valid + index) until reset or clr_first.
// Optional macro: AESL_AXIS_BLOCK_STAT_EN enables the block_cycle_cnt counter;
// without it, block_cycle_cnt is tied to zero.

// Per-channel wait tracker: IDLE -> COUNT -> BLOCKED.
module aesl_axis_block_chan #(
   parameter int CNT_W     = 8,
   parameter int THRESHOLD = 16,
   parameter bit CONSUMER  = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic active,
   input  logic tvalid,
   input  logic tready,
   output logic sig,
   output logic rise
);
   typedef enum logic [1:0] {IDLE, COUNT, BLOCKED} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESHOLD - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w;

   // A consumer waits on data, a producer waits on space; a transfer or an
   // idle owner is never a wait.
   assign w = active & (CONSUMER ? (tready & ~tvalid) : (tvalid & ~tready));

   // State and counter registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: COUNT leaves at THRESHOLD-1 so cnt never reaches THRESHOLD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (w) begin
               if (THRESHOLD == 1) begin
                  state_d = BLOCKED;
               end else begin
                  state_d = COUNT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         COUNT: begin
            if (!w) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == LAST) begin
               state_d = BLOCKED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BLOCKED: begin
            if (!w) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign sig  = (state_q == BLOCKED);
   // The block bit goes 0->1 at the coming edge.
   assign rise = (state_d == BLOCKED) & ~sig;
endmodule

module aesl_axis_block_detector #(
   parameter int                  NUM_CHAN  = 1,
   parameter int                  THRESHOLD = 16,
   parameter int                  CNT_W     = 8,
   parameter logic [NUM_CHAN-1:0] DIR_MASK  = '1,
   parameter int                  IDX_W     = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_CHAN-1:0] inst_active,
   input  logic [NUM_CHAN-1:0] tvalid,
   input  logic [NUM_CHAN-1:0] tready,
   input  logic                clr_first,
   output logic [NUM_CHAN-1:0] axis_block_sigs,
   output logic                first_block_valid,
   output logic [IDX_W-1:0]    first_block_idx,
   output logic [31:0]         block_cycle_cnt
);
   logic [NUM_CHAN-1:0] rise;
   logic [IDX_W-1:0]    rise_idx;

   for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
      aesl_axis_block_chan #(
         .CNT_W    (CNT_W),
         .THRESHOLD(THRESHOLD),
         .CONSUMER (DIR_MASK[g])
      ) u_chan (
         .clock (clock),
         .reset (reset),
         .active(inst_active[g]),
         .tvalid(tvalid[g]),
         .tready(tready[g]),
         .sig   (axis_block_sigs[g]),
         .rise  (rise[g])
      );
   end

   // Lowest rising channel: scan downward so the smallest index is written last.
   always_comb begin
      rise_idx = '0;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (rise[i]) rise_idx = IDX_W'(i);
      end
   end

   // Sticky first-block capture; a rise coinciding with clr_first wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         first_block_valid <= 1'b0;
         first_block_idx   <= '0;
      end else if ((|rise) && (!first_block_valid || clr_first)) begin
         first_block_valid <= 1'b1;
         first_block_idx   <= rise_idx;
      end else if (clr_first) begin
         first_block_valid <= 1'b0;
         first_block_idx   <= '0;
      end
   end

`ifdef AESL_AXIS_BLOCK_STAT_EN
   logic [31:0] stat_q;

   // Saturating count of cycles with any channel blocked; clear beats increment.
   always_ff @(posedge clock) begin
      if (reset || clr_first) begin
         stat_q <= '0;
      end else if ((|axis_block_sigs) && (stat_q != 32'hFFFF_FFFF)) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign block_cycle_cnt = stat_q;
`else
   assign block_cycle_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_aesl_axis_block_detector.sv
// Directed bench: dut_a is a single consumer channel with THRESHOLD=4,
// dut_b is three channels (ch1 consumer, ch0/ch2 producers) with THRESHOLD=2.
module tb_aesl_axis_block_detector;
   localparam bit STAT =
`ifdef AESL_AXIS_BLOCK_STAT_EN
      1'b1;
`else
      1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // dut_a signals
   logic        rst_a, clr_a;
   logic [0:0]  act_a, tv_a, tr_a, sig_a;
   logic        fv_a;
   logic [0:0]  idx_a;
   logic [31:0] bcc_a;

   // dut_b signals
   logic        rst_b, clr_b;
   logic [2:0]  act_b, tv_b, tr_b, sig_b;
   logic        fv_b;
   logic [1:0]  idx_b;
   logic [31:0] bcc_b;

   aesl_axis_block_detector #(
      .NUM_CHAN(1), .THRESHOLD(4), .CNT_W(8), .DIR_MASK(1'b1), .IDX_W(1)
   ) dut_a (
      .clock(clk), .reset(rst_a), .inst_active(act_a), .tvalid(tv_a),
      .tready(tr_a), .clr_first(clr_a), .axis_block_sigs(sig_a),
      .first_block_valid(fv_a), .first_block_idx(idx_a),
      .block_cycle_cnt(bcc_a)
   );

   aesl_axis_block_detector #(
      .NUM_CHAN(3), .THRESHOLD(2), .CNT_W(8), .DIR_MASK(3'b010), .IDX_W(2)
   ) dut_b (
      .clock(clk), .reset(rst_b), .inst_active(act_b), .tvalid(tv_b),
      .tready(tr_b), .clr_first(clr_b), .axis_block_sigs(sig_b),
      .first_block_valid(fv_b), .first_block_idx(idx_b),
      .block_cycle_cnt(bcc_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; clr_a = 1'b0; act_a = 1'b0; tv_a = 1'b0; tr_a = 1'b0;
      rst_b = 1'b1; clr_b = 1'b0; act_b = 3'b0; tv_b = 3'b0; tr_b = 3'b0;
      tick(); tick();
      if (sig_a !== 1'b0) $display("FAIL reset_sig_a got %0b exp 0", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b0) $display("FAIL reset_fv_a got %0b exp 0", fv_a); else n_pass++; n_checks++;
      if (idx_a !== 1'b0) $display("FAIL reset_idx_a got %0d exp 0", idx_a); else n_pass++; n_checks++;
      if (bcc_a !== 32'd0) $display("FAIL reset_bcc_a got %0d exp 0", bcc_a); else n_pass++; n_checks++;
      if (sig_b !== 3'b000) $display("FAIL reset_sig_b got %b exp 000", sig_b); else n_pass++; n_checks++;
      if (fv_b !== 1'b0) $display("FAIL reset_fv_b got %0b exp 0", fv_b); else n_pass++; n_checks++;
      rst_a = 1'b0; rst_b = 1'b0;
   endtask

   // Consumer waiting for data: bit rises at the 4th edge.
   task automatic test_threshold();
      act_a = 1'b1; tr_a = 1'b1; tv_a = 1'b0;
      tick(); tick(); tick();
      if (sig_a !== 1'b0) $display("FAIL thr_early got %0b exp 0", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b0) $display("FAIL thr_fv_early got %0b exp 0", fv_a); else n_pass++; n_checks++;
      tick();
      if (sig_a !== 1'b1) $display("FAIL thr_rise got %0b exp 1", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b1) $display("FAIL thr_fv got %0b exp 1", fv_a); else n_pass++; n_checks++;
      if (idx_a !== 1'b0) $display("FAIL thr_idx got %0d exp 0", idx_a); else n_pass++; n_checks++;
   endtask

   // Transfer breaks the wait streak; counting restarts from zero.
   task automatic test_restart();
      tv_a = 1'b1;
      tick();
      if (sig_a !== 1'b0) $display("FAIL rst_fall got %0b exp 0", sig_a); else n_pass++; n_checks++;
      tv_a = 1'b0;
      tick(); tick(); tick();
      tv_a = 1'b1;
      tick();
      if (sig_a !== 1'b0) $display("FAIL restart_no_block got %0b exp 0", sig_a); else n_pass++; n_checks++;
      tv_a = 1'b0;
      tick(); tick(); tick();
      if (sig_a !== 1'b0) $display("FAIL restart_early got %0b exp 0", sig_a); else n_pass++; n_checks++;
      tick();
      if (sig_a !== 1'b1) $display("FAIL restart_rise got %0b exp 1", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b1) $display("FAIL restart_fv_sticky got %0b exp 1", fv_a); else n_pass++; n_checks++;
   endtask

   // Inactive owner releases the bit; reset mid-count clears everything.
   task automatic test_inactive_and_reset();
      act_a = 1'b0;
      tick();
      if (sig_a !== 1'b0) $display("FAIL inact_fall got %0b exp 0", sig_a); else n_pass++; n_checks++;
      act_a = 1'b1;
      tick(); tick();
      rst_a = 1'b1;
      tick();
      if (sig_a !== 1'b0) $display("FAIL midreset_sig got %0b exp 0", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b0) $display("FAIL midreset_fv got %0b exp 0", fv_a); else n_pass++; n_checks++;
      if (idx_a !== 1'b0) $display("FAIL midreset_idx got %0d exp 0", idx_a); else n_pass++; n_checks++;
      rst_a = 1'b0; act_a = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      if (sig_a !== 1'b0) $display("FAIL post_reset_spurious got %0b exp 0", sig_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b0) $display("FAIL post_reset_fv got %0b exp 0", fv_a); else n_pass++; n_checks++;
   endtask

   // Statistic counter (or constant zero when the feature is compiled out).
   task automatic test_stat();
      act_a = 1'b1; tr_a = 1'b1; tv_a = 1'b0;
      tick(); tick(); tick(); tick();
      if (sig_a !== 1'b1) $display("FAIL stat_blocked got %0b exp 1", sig_a); else n_pass++; n_checks++;
      if (bcc_a !== 32'd0) $display("FAIL stat_start got %0d exp 0", bcc_a); else n_pass++; n_checks++;
      for (int i = 0; i < 10; i++) tick();
      if (bcc_a !== (STAT ? 32'd10 : 32'd0)) $display("FAIL stat_10 got %0d exp %0d", bcc_a, STAT ? 10 : 0); else n_pass++; n_checks++;
      clr_a = 1'b1;
      tick();
      clr_a = 1'b0;
      if (bcc_a !== 32'd0) $display("FAIL stat_clr got %0d exp 0", bcc_a); else n_pass++; n_checks++;
      if (fv_a !== 1'b0) $display("FAIL clr_fv got %0b exp 0", fv_a); else n_pass++; n_checks++;
      tick();
      if (bcc_a !== (STAT ? 32'd1 : 32'd0)) $display("FAIL stat_after_clr got %0d exp %0d", bcc_a, STAT ? 1 : 0); else n_pass++; n_checks++;
      if (sig_a !== 1'b1) $display("FAIL stat_still_blocked got %0b exp 1", sig_a); else n_pass++; n_checks++;
   endtask

   // Producers ch0/ch2 block together; lowest index captured, later ch1 ignored.
   task automatic test_multi_chan();
      act_b = 3'b111; tv_b = 3'b101; tr_b = 3'b000;
      tick();
      if (sig_b !== 3'b000) $display("FAIL multi_early got %b exp 000", sig_b); else n_pass++; n_checks++;
      tick();
      if (sig_b !== 3'b101) $display("FAIL multi_rise got %b exp 101", sig_b); else n_pass++; n_checks++;
      if (fv_b !== 1'b1) $display("FAIL multi_fv got %0b exp 1", fv_b); else n_pass++; n_checks++;
      if (idx_b !== 2'd0) $display("FAIL multi_idx got %0d exp 0", idx_b); else n_pass++; n_checks++;
      tr_b = 3'b010;
      tick(); tick();
      if (sig_b !== 3'b111) $display("FAIL multi_ch1 got %b exp 111", sig_b); else n_pass++; n_checks++;
      if (idx_b !== 2'd0) $display("FAIL multi_idx_held got %0d exp 0", idx_b); else n_pass++; n_checks++;
   endtask

   // clr_first at the same edge ch2 re-rises: the new rise is captured.
   task automatic test_clr_vs_rise();
      tv_b = 3'b001;
      tick();
      if (sig_b !== 3'b011) $display("FAIL clr_ch2_drop got %b exp 011", sig_b); else n_pass++; n_checks++;
      tv_b = 3'b101;
      tick();
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      if (sig_b !== 3'b111) $display("FAIL clr_ch2_rise got %b exp 111", sig_b); else n_pass++; n_checks++;
      if (fv_b !== 1'b1) $display("FAIL clr_rise_fv got %0b exp 1", fv_b); else n_pass++; n_checks++;
      if (idx_b !== 2'd2) $display("FAIL clr_rise_idx got %0d exp 2", idx_b); else n_pass++; n_checks++;
      clr_b = 1'b1;
      tick();
      clr_b = 1'b0;
      if (fv_b !== 1'b0) $display("FAIL clr_plain_fv got %0b exp 0", fv_b); else n_pass++; n_checks++;
      if (idx_b !== 2'd0) $display("FAIL clr_plain_idx got %0d exp 0", idx_b); else n_pass++; n_checks++;
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_restart();
      test_inactive_and_reset();
      test_stat();
      test_multi_chan();
      test_clr_vs_rise();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/aesl_axis_block_detector.md
Name: aesl_axis_block_detector

Overview:
- Cosim-testbench helper that watches the AXI-Stream handshakes of a dataflow instance and produces the per-channel `axis_block_sigs` vector used by the deadlock monitor.
- Each channel asserts its block bit after THRESHOLD consecutive cycles of one-sided waiting on its stream.
- Also captures, as a sticky flag plus index, the first channel that became blocked, for the testbench deadlock report.

Parameters:
- NUM_CHAN, 1, number of monitored AXI-Stream channels (>=1).
- THRESHOLD, 16, consecutive wait cycles before a channel is flagged (>=1, <=2^CNT_W).
- CNT_W, 8, stall counter width per channel.
- DIR_MASK, 1'b1 (NUM_CHAN bits), bit i=1: instance is consumer on channel i; bit i=0: instance is producer.
- IDX_W, 1, width of first_block_idx (>= clog2(NUM_CHAN), min 1).

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- inst_active  in  NUM_CHAN  bit i=1 while the process owning channel i is started and not idle.
- tvalid  in  NUM_CHAN  observed TVALID per channel.
- tready  in  NUM_CHAN  observed TREADY per channel.
- clr_first  in  1  one-cycle pulse, clears the sticky first-block capture.
- axis_block_sigs  out  NUM_CHAN  registered per-channel blocked flag.
- first_block_valid  out  1  sticky: some channel has blocked since reset/clear.
- first_block_idx  out  IDX_W  index of first channel blocked.
- block_cycle_cnt  out  32  optional statistic (see Optional Feature).

Behaviour:
- Wait condition per channel i, with w_i used in the rules below:
  - consumer: w_i = inst_active[i] & tready[i] & ~tvalid[i]
  - producer: w_i = inst_active[i] & tvalid[i] & ~tready[i]
  - a transfer (tvalid&tready) or an inactive instance means w_i=0.
- Per-channel FSM with states IDLE, COUNT and BLOCKED; cnt is CNT_W bits.
  - IDLE (cnt=0, sig=0):
    - w_i and THRESHOLD==1 -> BLOCKED
    - w_i otherwise -> COUNT with cnt=1
  - COUNT:
    - ~w_i -> IDLE, cnt=0
    - w_i and cnt==THRESHOLD-1 -> BLOCKED
    - w_i otherwise -> cnt+1
  - BLOCKED (sig=1, cnt held): ~w_i -> IDLE, cnt=0 (sig falls at that edge).
- Output timing: axis_block_sigs[i] = (state==BLOCKED), registered. It rises at the edge closing the THRESHOLD-th consecutive wait cycle and falls at the edge of the first non-wait cycle.
- The counter never wraps; COUNT exits before cnt reaches THRESHOLD.
- First capture: on any edge where some sig goes 0->1 and first_block_valid==0:
  - first_block_valid <= 1
  - first_block_idx <= lowest i rising at that edge.
- While first_block_valid==1, later rises are ignored.
- clr_first=1 -> first_block_valid <= 0, idx <= 0. If a rise occurs at the same edge as clr_first, the rise wins: valid=1 and idx=new index.
- Reset (any time, including mid-count or BLOCKED): all FSMs IDLE, cnt=0, axis_block_sigs=0, first_block_valid=0, first_block_idx=0, block_cycle_cnt=0.
- Channels are fully independent; simultaneous blocks are allowed.

Optional Feature:
- AESL_AXIS_BLOCK_STAT_EN defined:
  - block_cycle_cnt increments by 1 each cycle in which |axis_block_sigs==1.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset or clr_first; clr_first has priority over increment in the same cycle.
- Undefined: block_cycle_cnt is tied to 32'h0 and no counter logic is synthesized.

Test Plan:
1. NUM_CHAN=1, THRESHOLD=4, consumer, active=1, tready=1, tvalid=0 held -> axis_block_sigs[0] rises after 4th wait cycle (edge 4). first_block_valid=1, idx=0.
2. Same config, 3 wait cycles then one transfer (tvalid=1), then waiting again -> no assertion. The counter restarts and the bit asserts 4 cycles after the transfer.
3. NUM_CHAN=3, DIR_MASK=3'b010, THRESHOLD=2; channels 0 and 2 with tvalid=1, tready=0 from the same cycle -> both bits rise together. first_block_idx=0. A later ch1 block leaves idx unchanged.
4. Channel blocked, then inst_active[0] drops to 0 -> bit falls at that edge. Reset asserted mid-COUNT -> all outputs 0 next edge; no spurious block after reset release without new waits.
5. clr_first pulsed in the same cycle ch2 rises (ch0 previously captured) -> first_block_valid=1, idx=2.
6. With AESL_AXIS_BLOCK_STAT_EN, hold one channel blocked 10 cycles -> block_cycle_cnt=10. clr_first -> 0. Without the macro, block_cycle_cnt stays 0 throughout.
